// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter in front of a shared 32-bit ALU.
// Optional ALU_ARB_OPCHK_EN flags op codes 10-15 as illegal.
module alu_core (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result,
  output logic        o_zero
);
  always_comb begin
    o_result = 32'hBEEF_DEAD;
    case (i_op)
      4'd0: o_result = i_a + i_b;
      4'd1: o_result = i_a - i_b;
      4'd2: o_result = i_a & i_b;
      4'd3: o_result = i_a | i_b;
      4'd4: o_result = i_a ^ i_b;
      4'd5: o_result = i_a << i_b[4:0];
      4'd6: o_result = i_a >> i_b[4:0];
      4'd7: o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
      4'd8: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      4'd9: o_result = {31'd0, i_a < i_b};
      default: o_result = 32'hBEEF_DEAD;
    endcase
  end

  assign o_zero = (o_result == 32'd0);
endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             r_valid;
  logic             r_id;
  logic [31:0]      r_result;
  logic             r_zero;
  logic             r_err;
  logic             r_ptr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic        w_can_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_acc;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [3:0]  w_op;
  logic [31:0] w_alu_res;
  logic        w_alu_zero;
  logic [31:0] w_res;
  logic        w_zero;
  logic        w_err;

  assign w_can_accept = !r_valid || rsp_ready;

  // r_ptr holds the last granted requester; the other one wins a tie
  assign w_grant0 = req0_valid && (!req1_valid || r_ptr);
  assign w_grant1 = req1_valid && (!req0_valid || !r_ptr);

  assign req0_ready = w_grant0 && w_can_accept && !rst;
  assign req1_ready = w_grant1 && w_can_accept && !rst;

  assign w_acc0 = req0_valid && req0_ready;
  assign w_acc1 = req1_valid && req1_ready;
  assign w_acc  = w_acc0 || w_acc1;

  assign w_a  = w_acc1 ? req1_a  : req0_a;
  assign w_b  = w_acc1 ? req1_b  : req0_b;
  assign w_op = w_acc1 ? req1_op : req0_op;

  alu_core u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_alu_res),
    .o_zero   (w_alu_zero)
  );

`ifdef ALU_ARB_OPCHK_EN
  assign w_err  = (w_op > 4'd9);
  assign w_res  = w_err ? 32'd0 : w_alu_res;
  assign w_zero = w_err ? 1'b1  : w_alu_zero;
`else
  assign w_err  = 1'b0;
  assign w_res  = w_alu_res;
  assign w_zero = w_alu_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_id     <= 1'b0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_ptr    <= 1'b1;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else if (w_acc) begin
      r_valid  <= 1'b1;
      r_id     <= w_acc1;
      r_result <= w_res;
      r_zero   <= w_zero;
      r_err    <= w_err;
      r_ptr    <= w_acc1;
      if (w_acc0 && r_cnt0 != '1)
        r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_acc1 && r_cnt1 != '1)
        r_cnt1 <= r_cnt1 + CNT_ONE;
    end else if (r_valid && rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: op table, tie rotation,
// backpressure stall and mid-stream reset.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [15:0] cnt0, cnt1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t tv[11];
  int   exp_c0;
  int   exp_c1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 32'd3, 32'd3, 4'd1, 32'd0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 32'hF0F0, 32'hFF00, 4'd2, 32'hF000, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 32'h0F, 32'hF0, 4'd3, 32'hFF, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 32'hFF, 32'h0F, 4'd4, 32'hF0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 32'd1, 32'd4, 4'd5, 32'd16, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd0, 1'b1, 1'b0};
`ifdef ALU_ARB_OPCHK_EN
    tv[10] = '{1'b0, 32'd1, 32'd2, 4'd12, 32'd0, 1'b1, 1'b1};
`else
    tv[10] = '{1'b0, 32'd1, 32'd2, 4'd12, 32'hBEEF_DEAD, 1'b0, 1'b0};
`endif

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset();
    #1;
    chk("rst_valid",  rsp_valid,  0);
    chk("rst_id",     rsp_id,     0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero",   rsp_zero,   0);
    chk("rst_err",    rsp_err,    0);
    chk("rst_cnt0",   cnt0,       0);
    chk("rst_cnt1",   cnt1,       0);

    exp_c0 = 0;
    exp_c1 = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (tv[i].sel) begin
        req1_valid = 1'b1; req1_a = tv[i].a;
        req1_b = tv[i].b; req1_op = tv[i].op;
        exp_c1++;
      end else begin
        req0_valid = 1'b1; req0_a = tv[i].a;
        req0_b = tv[i].b; req0_op = tv[i].op;
        exp_c0++;
      end
      #1;
      chk($sformatf("v%0d_ready", i),
          tv[i].sel ? req1_ready : req0_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_id", i), rsp_id, tv[i].sel);
      chk($sformatf("v%0d_result", i), rsp_result, tv[i].res);
      chk($sformatf("v%0d_zero", i), rsp_zero, tv[i].zero);
      chk($sformatf("v%0d_err", i), rsp_err, tv[i].err);
      chk($sformatf("v%0d_cnt0", i), cnt0, exp_c0);
      chk($sformatf("v%0d_cnt1", i), cnt1, exp_c1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_drain", i), rsp_valid, 0);
    end

    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'd1;
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 4'd4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tie%0d_valid", k), rsp_valid, 1);
      chk($sformatf("tie%0d_id", k), rsp_id, k % 2);
      chk($sformatf("tie%0d_result", k), rsp_result,
          (k % 2) ? 32'hF0 : 32'd0);
      chk($sformatf("tie%0d_zero", k), rsp_zero, (k % 2) ? 0 : 1);
    end
    chk("tie_cnt0", cnt0, 2);
    chk("tie_cnt1", cnt1, 2);

    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", req0_ready, 0);
    chk("bp_ready1", req1_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d_id", k), rsp_id, 1);
      chk($sformatf("bp%0d_result", k), rsp_result, 32'hF0);
      chk($sformatf("bp%0d_cnt0", k), cnt0, 2);
      chk($sformatf("bp%0d_ready0", k), req0_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready0", req0_ready, 1);
    chk("rel_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("rel_valid", rsp_valid, 1);
    chk("rel_id", rsp_id, 0);
    chk("rel_result", rsp_result, 0);
    chk("rel_cnt0", cnt0, 3);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_ready0", req0_ready, 0);
    chk("mrst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_cnt0", cnt0, 0);
    chk("mrst_cnt1", cnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_ready0", req0_ready, 1);
    chk("post_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("post_id", rsp_id, 0);
    chk("post_valid", rsp_valid, 1);
    chk("post_cnt0", cnt0, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests (A, B, 4-bit op) from two independent valid/ready ports and issues at most one per cycle to an internally instantiated ALU. It captures result, Zero flag and requester ID in a one-entry output register with valid/ready backpressure. It sits between the execute-stage issue logic and any co-processor/AGU client that needs ALU time.

## Interface
- CNT_W, 16, width of per-requester issued-operation counters (saturating)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
- req0_a, req0_b  in  32  operands, requester 0
- req0_op  in  4  ALU operation code, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the held result
- rsp_result  out  32  ALU result
- rsp_zero  out  1  ALU Zero flag for that result
- rsp_err  out  1  illegal op code (only with ALU_ARB_OPCHK_EN; tied 0 otherwise)
- cnt0, cnt1  out  CNT_W  operations accepted from requester 0 / 1

## Operation
- can_accept = !rsp_valid | rsp_ready (empty, or draining this cycle).
- Grant: only one valid -> that requester; both valid -> requester not granted last; neither -> no grant.
- reqN_ready = grant[N] & can_accept. This is combinational from valids, pointer, rsp_valid and rsp_ready. reqN_ready never depends on reqN_* data.
- Accept (reqN_valid & reqN_ready): the granted a/b/op drive the ALU. The output register loads result, zero, id=N, rsp_valid=1. The last-grant pointer is set to N. cntN increments, saturating at all-ones.
- Pointer changes only on an accept. A stalled grant (can_accept=0) does not rotate the pointer.
- Drain without accept: rsp_valid & rsp_ready with no accept -> rsp_valid=0 next cycle.
- Drain plus accept in the same cycle: the register reloads and rsp_valid stays 1. There is no bubble.
- Output fields are held stable while rsp_valid & !rsp_ready.
- Requesters may drop valid or change data while not ready. The arbiter holds no request state.
- Op codes 0–9 follow the ALU encoding: add, sub, and, or, xor, sll, srl, sra, slt, sltu.

## Timing
- Latency: 1 cycle, accept at edge k -> rsp_valid=1 after edge k.
- Throughput: 1 op/cycle with rsp_ready held high. Under tie, service alternates 0,1,0,1.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, cnt0=cnt1=0. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- Reset mid-operation: any held result is discarded. Accepts and drains in the reset cycle are ignored. reqN_ready=0 while rst=1.
- Starvation bound: a continuously valid requester is accepted within 2 accept slots.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - Op codes 10–15 are accepted normally.
  - The response has rsp_err=1 and rsp_result=0, rsp_zero=1. The ALU default value is not forwarded.
  - The counter still increments.
- ALU_ARB_OPCHK_EN undefined:
  - rsp_err is constant 0.
  - Op codes 10–15 return the ALU default output (32'hBEEF_DEAD, zero=0).

## Test plan
- Single op: after reset, req0 add 5+7 with rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=12, zero=0; cnt0=1.
- Tie and rotation: both valid every cycle, req0 sub 3-3, req1 xor 0xFF^0x0F, rsp_ready=1 -> ids 0,1,0,1.
  - Result 0 comes with zero=1.
  - Result 0xF0 comes with zero=0.
- Backpressure: rsp_ready=0 with a result held and both valid -> both ready=0 and outputs stable for 3 cycles.
  - rsp_ready=1 -> same-cycle accept, no bubble, pointer unchanged during the stall.
- Shifts and compares:
  - sra 0x80000000 by 4 -> 0xF8000000.
  - slt -1<1 -> 1.
  - sltu 0xFFFFFFFF<1 -> 0.
- Illegal op 12:
  - With ALU_ARB_OPCHK_EN: err=1, result=0, zero=1.
  - Without it: result=0xBEEFDEAD, err=0.
- Reset mid-stream: assert rst while rsp_valid=1 -> next cycle rsp_valid=0, counters 0. The first tie after release grants requester 0.
